// File: rtl/softmax_pkg.sv
// Shared widths, element types and FSM encoding for the softmax denominator path.
package softmax_pkg;

  localparam int LANES_DEF   = 16;
  localparam int EXP_W_DEF   = 16;
  localparam int DENOM_W_DEF = 18;

  typedef logic [EXP_W_DEF-1:0]   exp_t;
  typedef logic [DENOM_W_DEF-1:0] denom_t;

  typedef enum logic {
    ACCUM,
    HOLD
  } acc_state_e;

endpackage

// File: rtl/sat_accum_lane.sv
// One lane of the denominator: saturating running sum with a sticky overflow flag.
module sat_accum_lane #(
  parameter int EXP_W   = 16,
  parameter int DENOM_W = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               add,
  input  logic               clear,
  input  logic [EXP_W-1:0]   exp_in,
  output logic [DENOM_W-1:0] sum,
  output logic               sat
);

  logic [DENOM_W-1:0] acc;
  logic               sat_q;
  logic [DENOM_W:0]   wide;

  // sum/sat are the values this lane would hold after accepting exp_in,
  // so the top can capture a row's final result on its last beat.
  always_comb begin
    wide = {1'b0, acc} + (DENOM_W+1)'(exp_in);
    sat  = sat_q | wide[DENOM_W];
    sum  = sat ? '1 : wide[DENOM_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else if (add) begin
      acc   <= sum;
      sat_q <= sat;
    end
  end

endmodule

// File: rtl/softmax_denom_accum.sv
// Sums exponent beats per row across LANES lanes and holds the denominators
// until the reciprocal stage takes them.
module softmax_denom_accum
  import softmax_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int COLS    = 16,
  parameter int EXP_W   = EXP_W_DEF,
  parameter int DENOM_W = DENOM_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_exp_valid,
  output logic                     o_exp_ready,
  input  logic [LANES*EXP_W-1:0]   i_exp,
  input  logic                     i_exp_last,
  output logic                     o_denom_valid,
  input  logic                     i_denom_ready,
  output logic [LANES*DENOM_W-1:0] o_denom,
  output logic [LANES-1:0]         o_sat,
  output logic [LANES-1:0]         o_zero,
  output logic                     o_last_err
);

  localparam int CNT_W = $clog2(COLS);

  acc_state_e               state;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     accept;
  logic                     final_beat;
  logic [LANES*DENOM_W-1:0] sum_next;
  logic [LANES-1:0]         sat_next;

  assign accept     = i_exp_valid && o_exp_ready;
  assign final_beat = (beat_cnt == CNT_W'(COLS-1));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sat_accum_lane #(
      .EXP_W   (EXP_W),
      .DENOM_W (DENOM_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .add    (accept),
      .clear  (accept && final_beat),
      .exp_in (i_exp[k*EXP_W +: EXP_W]),
      .sum    (sum_next[k*DENOM_W +: DENOM_W]),
      .sat    (sat_next[k])
    );
  end

  // The beat counter alone ends a row; i_exp_last only feeds the sticky error.
  // A zero sum is bumped to 1 LSB so the reciprocal never sees a divide-by-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACCUM;
      beat_cnt      <= '0;
      o_exp_ready   <= 1'b1;
      o_denom_valid <= 1'b0;
      o_denom       <= '0;
      o_sat         <= '0;
      o_zero        <= '0;
      o_last_err    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (i_exp_last != final_beat) o_last_err <= 1'b1;
            if (final_beat) begin
              beat_cnt      <= '0;
              state         <= HOLD;
              o_exp_ready   <= 1'b0;
              o_denom_valid <= 1'b1;
              o_sat         <= sat_next;
              for (int k = 0; k < LANES; k++) begin
                if (sum_next[k*DENOM_W +: DENOM_W] == '0) begin
                  o_denom[k*DENOM_W +: DENOM_W] <= DENOM_W'(1);
                  o_zero[k]                     <= 1'b1;
                end else begin
                  o_denom[k*DENOM_W +: DENOM_W] <= sum_next[k*DENOM_W +: DENOM_W];
                  o_zero[k]                     <= 1'b0;
                end
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (i_denom_ready) begin
            state         <= ACCUM;
            o_denom_valid <= 1'b0;
            o_exp_ready   <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_denom_accum.sv
// Self-checking bench: table-driven rows on a COLS=4 instance with a result
// scoreboard, plus hand-written corner sequences and a COLS=8 saturation case.
module tb_softmax_denom_accum;
  import softmax_pkg::*;

  localparam int LANES   = 16;
  localparam int EXP_W   = 16;
  localparam int DENOM_W = 18;
  localparam int EW      = LANES*EXP_W;
  localparam int DW      = LANES*DENOM_W;

  typedef struct {
    logic [15:0] e0, e1, er;
    logic [17:0] d0, d1, dr;
    logic [15:0] sat, zero;
  } row_t;

  typedef struct {
    logic [DW-1:0]    denom;
    logic [LANES-1:0] sat;
    logic [LANES-1:0] zero;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             exp_valid, exp_ready, exp_last;
  logic [EW-1:0]    exp_data;
  logic             denom_valid, denom_ready, last_err;
  logic [DW-1:0]    denom;
  logic [LANES-1:0] sat, zero;

  logic             exp_valid8, exp_ready8, exp_last8;
  logic [EW-1:0]    exp_data8;
  logic             denom_valid8, denom_ready8, last_err8;
  logic [DW-1:0]    denom8;
  logic [LANES-1:0] sat8, zero8;

  res_t sb_q[$];
  res_t mon_e;
  row_t rows[4];
  int   errors = 0;
  int   checks = 0;

  softmax_denom_accum #(.COLS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_exp_valid(exp_valid), .o_exp_ready(exp_ready), .i_exp(exp_data), .i_exp_last(exp_last),
    .o_denom_valid(denom_valid), .i_denom_ready(denom_ready), .o_denom(denom),
    .o_sat(sat), .o_zero(zero), .o_last_err(last_err)
  );

  softmax_denom_accum #(.COLS(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .i_exp_valid(exp_valid8), .o_exp_ready(exp_ready8), .i_exp(exp_data8), .i_exp_last(exp_last8),
    .o_denom_valid(denom_valid8), .i_denom_ready(denom_ready8), .o_denom(denom8),
    .o_sat(sat8), .o_zero(zero8), .o_last_err(last_err8)
  );

  function automatic logic [EW-1:0] pack_exp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
    logic [EW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*EXP_W +: EXP_W] = (k == 0) ? a : (k == 1) ? b : r;
    return v;
  endfunction

  function automatic logic [DW-1:0] pack_den(input logic [17:0] a, input logic [17:0] b, input logic [17:0] r);
    logic [DW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DENOM_W +: DENOM_W] = (k == 0) ? a : (k == 1) ? b : r;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard: every output handshake on the COLS=4 instance pops one expectation.
  always @(negedge clk) begin
    if (rst_n && denom_valid && denom_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got %h, required no result", denom);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("sb_denom", denom, mon_e.denom);
        checkOutput("sb_sat", DW'(sat), DW'(mon_e.sat));
        checkOutput("sb_zero", DW'(zero), DW'(mon_e.zero));
      end
    end
  end

  // Entered and left at posedge+1; returns once the beat was taken at an edge.
  task automatic send_beat(input logic [EW-1:0] data, input logic last);
    logic was_ready;
    int   n;
    exp_valid = 1'b1;
    exp_data  = data;
    exp_last  = last;
    n = 0;
    do begin
      was_ready = exp_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!was_ready && n < 100);
    if (!was_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_timeout: got ready=0, required ready=1 within 100 cycles");
    end
    exp_valid = 1'b0;
    exp_last  = 1'b0;
  endtask

  task automatic send_beat8(input logic [EW-1:0] data, input logic last);
    logic was_ready;
    int   n;
    exp_valid8 = 1'b1;
    exp_data8  = data;
    exp_last8  = last;
    n = 0;
    do begin
      was_ready = exp_ready8;
      @(posedge clk);
      #1;
      n++;
    end while (!was_ready && n < 100);
    if (!was_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat8_timeout: got ready=0, required ready=1 within 100 cycles");
    end
    exp_valid8 = 1'b0;
    exp_last8  = 1'b0;
  endtask

  task automatic applyStimulus(input row_t r, input int last_at);
    res_t e;
    e.denom = pack_den(r.d0, r.d1, r.dr);
    e.sat   = r.sat;
    e.zero  = r.zero;
    sb_q.push_back(e);
    for (int b = 0; b < 4; b++) send_beat(pack_exp(r.e0, r.e1, r.er), (b == last_at));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    row_t r;
    rows[0] = '{16'h0080, 16'h0080, 16'h0080, 18'h00200, 18'h00200, 18'h00200, 16'h0000, 16'h0000};
    rows[1] = '{16'h0000, 16'h0040, 16'h0080, 18'h00001, 18'h00100, 18'h00200, 16'h0000, 16'h0001};
    rows[2] = '{16'hFFFF, 16'h0001, 16'h1234, 18'h3FFFC, 18'h00004, 18'h048D0, 16'h0000, 16'h0000};
    rows[3] = '{16'h0000, 16'hFFFF, 16'h0001, 18'h00001, 18'h3FFFC, 18'h00004, 16'h0000, 16'h0001};

    rst_n = 1'b0;
    exp_valid = 0; exp_last = 0; exp_data = '0; denom_ready = 1'b1;
    exp_valid8 = 0; exp_last8 = 0; exp_data8 = '0; denom_ready8 = 1'b1;
    #13;
    checkOutput("rst_exp_ready", DW'(exp_ready), DW'(1));
    checkOutput("rst_denom_valid", DW'(denom_valid), DW'(0));
    checkOutput("rst_denom", denom, '0);
    checkOutput("rst_sat", DW'(sat), DW'(0));
    checkOutput("rst_zero", DW'(zero), DW'(0));
    checkOutput("rst_last_err", DW'(last_err), DW'(0));
    checkOutput("rst_exp_ready8", DW'(exp_ready8), DW'(1));
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) applyStimulus(rows[i], 3);
    drain();
    checkOutput("last_err_clean", DW'(last_err), DW'(0));

    // Backpressure: result must hold steady while downstream stalls.
    denom_ready = 1'b0;
    r = '{16'h0100, 16'h0100, 16'h0100, 18'h00400, 18'h00400, 18'h00400, 16'h0000, 16'h0000};
    applyStimulus(r, 3);
    checkOutput("lat_valid", DW'(denom_valid), DW'(1));
    checkOutput("hold_exp_ready", DW'(exp_ready), DW'(0));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", DW'(denom_valid), DW'(1));
      checkOutput("bp_denom", denom, pack_den(18'h00400, 18'h00400, 18'h00400));
      checkOutput("bp_exp_ready", DW'(exp_ready), DW'(0));
    end
    denom_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("hs_valid_drop", DW'(denom_valid), DW'(0));
    checkOutput("hs_exp_ready", DW'(exp_ready), DW'(1));
    r = '{16'h0003, 16'h0000, 16'h0010, 18'h0000C, 18'h00001, 18'h00040, 16'h0000, 16'h0002};
    applyStimulus(r, 3);
    drain();

    // Misplaced last marker: sticky error, row still closes on the count.
    applyStimulus(rows[0], 1);
    drain();
    checkOutput("last_err_set", DW'(last_err), DW'(1));
    applyStimulus(rows[2], 3);
    drain();
    checkOutput("last_err_sticky", DW'(last_err), DW'(1));

    // Asynchronous reset mid-row discards the partial sum.
    send_beat(pack_exp(16'h0080, 16'h0080, 16'h0080), 1'b0);
    send_beat(pack_exp(16'h0080, 16'h0080, 16'h0080), 1'b0);
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    checkOutput("mid_rst_last_err", DW'(last_err), DW'(0));
    checkOutput("mid_rst_ready", DW'(exp_ready), DW'(1));
    checkOutput("mid_rst_valid", DW'(denom_valid), DW'(0));
    @(posedge clk);
    #1;
    applyStimulus(rows[0], 3);
    drain();

    // COLS=8: saturating row, then a small row proving the sticky bit cleared.
    for (int b = 0; b < 8; b++) send_beat8(pack_exp(16'hFFFF, 16'hFFFF, 16'hFFFF), (b == 7));
    checkOutput("sat8_valid", DW'(denom_valid8), DW'(1));
    checkOutput("sat8_denom", denom8, pack_den(18'h3FFFF, 18'h3FFFF, 18'h3FFFF));
    checkOutput("sat8_sat", DW'(sat8), DW'(16'hFFFF));
    checkOutput("sat8_zero", DW'(zero8), DW'(0));
    for (int b = 0; b < 8; b++) send_beat8(pack_exp(16'h0001, 16'h0001, 16'h0001), (b == 7));
    checkOutput("small8_valid", DW'(denom_valid8), DW'(1));
    checkOutput("small8_denom", denom8, pack_den(18'h00008, 18'h00008, 18'h00008));
    checkOutput("small8_sat", DW'(sat8), DW'(0));
    checkOutput("small8_last_err", DW'(last_err8), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
